// File: rtl/stopwatch_lap_controller_if.sv
// Signal bundle between the button/stopwatch side and the lap controller.
// The controller sits on the slave modport; the button/stopwatch/display side uses master.
interface stopwatch_lap_controller_if;
  logic       btn_a;
  logic       btn_b;
  logic [9:0] time_ms;
  logic [5:0] time_sec;
  logic [5:0] time_min;
  logic       sw_start;
  logic       sw_stop;
  logic       sw_clear;
  logic [1:0] state;
  logic [9:0] disp_ms;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic       disp_is_lap;
  logic [3:0] lap_index;
  logic [3:0] lap_count;
  logic       lap_full;

  modport master (
    output btn_a, btn_b, time_ms, time_sec, time_min,
    input  sw_start, sw_stop, sw_clear, state, disp_ms, disp_sec, disp_min,
           disp_is_lap, lap_index, lap_count, lap_full
  );

  modport slave (
    input  btn_a, btn_b, time_ms, time_sec, time_min,
    output sw_start, sw_stop, sw_clear, state, disp_ms, disp_sec, disp_min,
           disp_is_lap, lap_index, lap_count, lap_full
  );
endinterface

// File: rtl/stopwatch_lap_controller.sv
// Two-button stopwatch sequencer: start/stop/clear pulses, lap capture and display source select.
// Everything runs in the 1 kHz domain; all outputs are registered.
module stopwatch_lap_controller #(
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned HOLD_MS   = 2000,
  parameter int unsigned CLEAR_MS  = 1000
) (
  input logic                       clk1KHz,
  input logic                       reset,
  stopwatch_lap_controller_if.slave bus
);
  localparam int unsigned IW = $clog2(LAP_DEPTH);
  localparam int unsigned HW = $clog2(HOLD_MS + 1);
  localparam int unsigned CW = $clog2(CLEAR_MS + 1);
  localparam logic [3:0]    LapMax    = 4'(LAP_DEPTH);
  localparam logic [HW-1:0] HoldLoad  = HW'(HOLD_MS);
  localparam logic [CW-1:0] ClearLast = CW'(CLEAR_MS - 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StRunning = 2'd1, StPaused = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          btn_a_q, btn_b_q;
  logic          sw_start_q, sw_start_d, sw_stop_q, sw_stop_d, sw_clear_q, sw_clear_d;
  logic [3:0]    lap_count_q, lap_count_d, lap_index_q, lap_index_d;
  logic          lap_full_q;
  logic          disp_is_lap_q, disp_is_lap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] press_cnt_q, press_cnt_d;
  logic [9:0]    disp_ms_q, disp_ms_d;
  logic [5:0]    disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
  logic          lap_we;
  logic          a_press, b_press;
  logic [3:0]    recall_idx, prev_idx;
  logic [21:0]   split, cur, prev;
  logic [21:0]   lap_mem [LAP_DEPTH];
  logic [10:0]   ms_sub;
  logic [6:0]    sec_sub, min_sub;
  logic [9:0]    d_ms;
  logic [5:0]    d_sec, d_min;

  assign a_press    = bus.btn_a & ~btn_a_q;
  assign b_press    = bus.btn_b & ~btn_b_q;
  assign split      = {bus.time_min, bus.time_sec, bus.time_ms};
  assign recall_idx = lap_index_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    sw_start_d    = 1'b0;
    sw_stop_d     = 1'b0;
    sw_clear_d    = 1'b0;
    lap_count_d   = lap_count_q;
    lap_index_d   = lap_index_q;
    disp_is_lap_d = disp_is_lap_q;
    hold_d        = hold_q;
    press_cnt_d   = press_cnt_q;
    lap_we        = 1'b0;

    if (disp_is_lap_q) begin
      if (hold_q == HW'(1)) begin
        disp_is_lap_d = 1'b0;
        hold_d        = '0;
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (a_press) begin
          sw_start_d = 1'b1;
          state_d    = StRunning;
        end
      end
      StRunning: begin
        if (a_press) begin
          sw_stop_d     = 1'b1;
          state_d       = StPaused;
          disp_is_lap_d = 1'b0;
          hold_d        = '0;
        end else if (b_press && lap_count_q < LapMax) begin
          lap_we        = 1'b1;
          lap_count_d   = lap_count_q + 4'd1;
          lap_index_d   = lap_count_q;
          disp_is_lap_d = 1'b1;
          hold_d        = HoldLoad;
        end
      end
      StPaused: begin
        if (a_press) begin
          sw_start_d  = 1'b1;
          state_d     = StRunning;
          press_cnt_d = '0;
        end else if (b_press) begin
          press_cnt_d = CW'(1);
        end else if (press_cnt_q != '0) begin
          // A tracked press is still held unless btn_b just dropped.
          if (!bus.btn_b) begin
            press_cnt_d = '0;
            if (lap_count_q != 4'd0) begin
              hold_d = HoldLoad;
              if (!disp_is_lap_q) begin
                lap_index_d   = 4'd0;
                disp_is_lap_d = 1'b1;
              end else if (recall_idx == lap_count_q) begin
                disp_is_lap_d = 1'b0;
                hold_d        = '0;
              end else begin
                lap_index_d   = recall_idx;
                disp_is_lap_d = 1'b1;
              end
            end
          end else if (press_cnt_q == ClearLast) begin
            sw_clear_d    = 1'b1;
            lap_count_d   = 4'd0;
            disp_is_lap_d = 1'b0;
            hold_d        = '0;
            press_cnt_d   = '0;
            state_d       = StIdle;
          end else begin
            press_cnt_d = press_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Delta of the entry about to be shown; a lap written this cycle is taken from the live split.
  always_comb begin
    prev_idx = lap_index_d - 4'd1;
    cur      = lap_we ? split : lap_mem[lap_index_d[IW-1:0]];
    prev     = (lap_index_d == 4'd0) ? '0 : lap_mem[prev_idx[IW-1:0]];
    ms_sub   = {1'b0, cur[9:0]} - {1'b0, prev[9:0]};
    d_ms     = ms_sub[10] ? ms_sub[9:0] + 10'd1000 : ms_sub[9:0];
    sec_sub  = {1'b0, cur[15:10]} - {1'b0, prev[15:10]} - {6'd0, ms_sub[10]};
    d_sec    = sec_sub[6] ? sec_sub[5:0] + 6'd60 : sec_sub[5:0];
    min_sub  = {1'b0, cur[21:16]} - {1'b0, prev[21:16]} - {6'd0, sec_sub[6]};
    d_min    = min_sub[6] ? min_sub[5:0] + 6'd60 : min_sub[5:0];

    disp_ms_d  = bus.time_ms;
    disp_sec_d = bus.time_sec;
    disp_min_d = bus.time_min;
    if (disp_is_lap_d) begin
      disp_ms_d  = d_ms;
      disp_sec_d = d_sec;
      disp_min_d = d_min;
    end
  end

  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      btn_a_q       <= 1'b0;
      btn_b_q       <= 1'b0;
      sw_start_q    <= 1'b0;
      sw_stop_q     <= 1'b0;
      sw_clear_q    <= 1'b0;
      lap_count_q   <= 4'd0;
      lap_index_q   <= 4'd0;
      lap_full_q    <= 1'b0;
      disp_is_lap_q <= 1'b0;
      hold_q        <= '0;
      press_cnt_q   <= '0;
      disp_ms_q     <= 10'd0;
      disp_sec_q    <= 6'd0;
      disp_min_q    <= 6'd0;
    end else begin
      state_q       <= state_d;
      btn_a_q       <= bus.btn_a;
      btn_b_q       <= bus.btn_b;
      sw_start_q    <= sw_start_d;
      sw_stop_q     <= sw_stop_d;
      sw_clear_q    <= sw_clear_d;
      lap_count_q   <= lap_count_d;
      lap_index_q   <= lap_index_d;
      lap_full_q    <= (lap_count_d == LapMax);
      disp_is_lap_q <= disp_is_lap_d;
      hold_q        <= hold_d;
      press_cnt_q   <= press_cnt_d;
      disp_ms_q     <= disp_ms_d;
      disp_sec_q    <= disp_sec_d;
      disp_min_q    <= disp_min_d;
    end
  end

  always_ff @(posedge clk1KHz) begin
    if (lap_we) lap_mem[lap_count_q[IW-1:0]] <= split;
  end

  assign bus.sw_start    = sw_start_q;
  assign bus.sw_stop     = sw_stop_q;
  assign bus.sw_clear    = sw_clear_q;
  assign bus.state       = state_q;
  assign bus.disp_ms     = disp_ms_q;
  assign bus.disp_sec    = disp_sec_q;
  assign bus.disp_min    = disp_min_q;
  assign bus.disp_is_lap = disp_is_lap_q;
  assign bus.lap_index   = lap_index_q;
  assign bus.lap_count   = lap_count_q;
  assign bus.lap_full    = lap_full_q;
endmodule

// File: doc/stopwatch_lap_controller.md
Name: stopwatch_lap_controller

Overview:
- Two-button sequencer for the stopwatch: drives its start/stop/clear controls, captures up to LAP_DEPTH split times into an internal lap buffer and selects what the display shows.
- Display source is either the live stopwatch time or a stored lap delta.
- Runs entirely in the 1 kHz domain. Sits between the debounced push-buttons and the stopwatch/display path.

Parameters:
LAP_DEPTH, 8, number of lap entries stored (2..15)
HOLD_MS, 2000, clk1KHz cycles a lap delta stays on the display
CLEAR_MS, 1000, clk1KHz cycles btn_b must be held in PAUSED to clear

Ports:
clk1KHz  in  1  1 kHz clock
reset  in  1  asynchronous, active-high reset
btn_a  in  1  start/stop button, debounced level, synchronous to clk1KHz
btn_b  in  1  lap/recall/clear button, debounced level, synchronous to clk1KHz
time_ms  in  10  live stopwatch ms (0..999)
time_sec  in  6  live stopwatch seconds (0..59)
time_min  in  6  live stopwatch minutes (0..59)
sw_start  out  1  one-cycle start pulse to stopwatch
sw_stop  out  1  one-cycle stop pulse to stopwatch
sw_clear  out  1  one-cycle clear pulse to stopwatch (stopwatch reset)
state  out  2  0=IDLE, 1=RUNNING, 2=PAUSED
disp_ms  out  10  displayed ms
disp_sec  out  6  displayed seconds
disp_min  out  6  displayed minutes
disp_is_lap  out  1  1 = display shows a lap delta
lap_index  out  4  index of the lap shown (valid when disp_is_lap=1)
lap_count  out  4  laps stored (0..LAP_DEPTH)
lap_full  out  1  lap_count == LAP_DEPTH

Behaviour:
- Reset (async): state=IDLE; all pulses 0; lap_count=0; lap_index=0; hold and press counters 0; disp_is_lap=0; disp_* = 0.
- Buttons are registered each cycle (btn_x_q). A press event is btn_x & ~btn_x_q. A release event is ~btn_x & btn_x_q.
- All outputs are registered. Every reaction is visible in the cycle after the edge at which the event is detected.
- If btn_a and btn_b events occur in the same cycle, btn_a wins and the btn_b event is dropped.
- IDLE:
  - btn_a press -> sw_start=1 for 1 cycle, go to RUNNING.
  - btn_b is ignored.
- RUNNING:
  - btn_a press -> sw_stop=1 for 1 cycle, go to PAUSED; any hold is cancelled (disp_is_lap=0).
  - btn_b press with lap_count<LAP_DEPTH:
    - split = {time_min,time_sec,time_ms} as sampled at that edge is written to lap_mem[lap_count].
    - lap_count increments.
    - lap_index = old lap_count; disp_is_lap=1; hold counter loaded with HOLD_MS.
  - btn_b press when lap_full -> no write, no display change.
- PAUSED:
  - btn_a press -> sw_start=1, go to RUNNING.
  - btn_b held CLEAR_MS consecutive cycles (counted from the press edge):
    - sw_clear=1 for 1 cycle; lap_count=0; disp_is_lap=0; go to IDLE.
    - The subsequent release is ignored.
  - btn_b released before CLEAR_MS (short press) with lap_count>0 -> recall:
    - If disp_is_lap=0, show lap 0.
    - Otherwise show lap_index+1.
    - Showing index lap_count returns to live (disp_is_lap=0).
    - Each recall reloads the hold counter.
  - Short press with lap_count=0 -> ignored.
- Hold:
  - While disp_is_lap=1 the counter decrements each cycle.
  - When the counter reaches 1, the next cycle sets disp_is_lap=0. A lap stays displayed for exactly HOLD_MS cycles.
  - A new lap or recall restarts the hold.
- Display:
  - disp_is_lap=0 -> disp_* = time_* registered (1-cycle latency).
  - disp_is_lap=1 -> disp_* = delta(lap_index).
- Delta arithmetic:
  - delta(k) = lap_mem[k] - lap_mem[k-1], with lap_mem[-1] = 0.
  - Subtraction uses per-field borrow: ms modulo 1000, sec modulo 60, min modulo 60.
  - Because the final minute borrow is discarded, a split taken after the stopwatch wraps 59:59.999 -> 00:00.000 yields the correct modulo-60-minute delta.
- Timing: pulses are never asserted for more than one cycle. State and pulses update on the same edge.

Test Plan:
- Reset, then btn_a high for 5 cycles -> sw_start=1 for exactly 1 cycle; state=1; no further pulses while held.
- RUNNING, time=00:01.250, btn_b press -> lap_count=1; disp_is_lap=1; disp=00:01.250 for 2000 cycles, then live.
- Lap at 00:01.250, then lap at 00:03.100 -> disp=00:01.850, lap_index=1.
- Splits 59:59.900 then 00:00.150 (wrapped) -> delta=00:00.250.
- Store 8 laps, 9th btn_b press -> lap_count stays 8, lap_full=1, display unchanged. Then btn_a -> sw_stop=1, state=2.
- PAUSED with 3 laps:
  - Four short btn_b presses -> lap_index 0, 1, 2, then live.
  - btn_b held 1000 cycles -> sw_clear=1 once, lap_count=0, state=0.
  - Simultaneous btn_a+btn_b press -> only sw_start.
